csr_counters: RTL and testbench

- Parametrised machine counter/performance-monitor CSR bank: mcycle, minstret, NUM_HPM mhpmcounters, mcountinhibit, mhpmevent selectors, user read-only shadows, and a sticky overflow register with interrupt output.
- Sits beside the main CSR file in the ID/EX stage. Shares the csr address/op/wdata bus; the core muxes csr_rdata_o when csr_hit_o is set.
- Generalises the fixed-register CSR file to configurable counter count and counter width, with event-driven counting.

---
 rtl/csr_counters_pkg.sv | 66 ++++++
 rtl/csr_counters_counter.sv | 69 ++++++
 rtl/csr_counters.sv | 204 ++++++++++++++++++++
 tb/tb_csr_counters.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_counters_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counters_pkg
//  Description : Shared types and address constants for the machine
//                counter / performance-monitor CSR bank.
//                - csr_addr_t / csr_operation_t : CSR bus types
//                - CSR_* : counter-related CSR addresses
//                - impl_mask() : implemented-counter bit mask
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_counters_pkg;

  typedef logic [11:0] csr_addr_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_operation_t;

  // Index of the first hardware performance counter (mhpmcounter3).
  localparam int HPM_BASE_IDX = 3;

  // Machine counters (low / high halves).
  localparam csr_addr_t CSR_MCYCLE         = 12'hB00;
  localparam csr_addr_t CSR_MCYCLEH        = 12'hB80;
  localparam csr_addr_t CSR_MINSTRET       = 12'hB02;
  localparam csr_addr_t CSR_MINSTRETH      = 12'hB82;
  localparam csr_addr_t CSR_MHPMCOUNTER3   = 12'hB03;
  localparam csr_addr_t CSR_MHPMCOUNTER3H  = 12'hB83;

  // Counter control.
  localparam csr_addr_t CSR_MCOUNTINHIBIT  = 12'h320;
  localparam csr_addr_t CSR_MHPMEVENT3     = 12'h323;
  localparam csr_addr_t CSR_MCOUNTEROVF    = 12'h7C0;

  // User read-only shadows.
  localparam csr_addr_t CSR_CYCLE          = 12'hC00;
  localparam csr_addr_t CSR_CYCLEH         = 12'hC80;
  localparam csr_addr_t CSR_INSTRET        = 12'hC02;
  localparam csr_addr_t CSR_INSTRETH       = 12'hC82;
  localparam csr_addr_t CSR_HPMCOUNTER3    = 12'hC03;
  localparam csr_addr_t CSR_HPMCOUNTER3H   = 12'hC83;

  // Each counter family occupies a 32-entry page; addr[11:5] selects the
  // page and addr[4:0] the counter index.
  localparam logic [6:0] CNT_LO_PAGE = CSR_MCYCLE[11:5];
  localparam logic [6:0] CNT_HI_PAGE = CSR_MCYCLEH[11:5];
  localparam logic [6:0] SHD_LO_PAGE = CSR_CYCLE[11:5];
  localparam logic [6:0] SHD_HI_PAGE = CSR_CYCLEH[11:5];
  localparam logic [6:0] EVT_PAGE    = CSR_MHPMEVENT3[11:5];

  // Bit i set when counter i exists: cycle (0), instret (2) and
  // hpm 3 .. 3+num_hpm-1. Bit 1 (time) is never implemented here.
  function automatic logic [31:0] impl_mask(input int num_hpm);
    logic [31:0] m;
    m = 32'h0000_0005;
    for (int k = 0; k < num_hpm; k++) begin
      m[HPM_BASE_IDX + k] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counters_counter.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counter
//  Description : One WIDTH-bit event counter with 32-bit split write access.
//                A write to either half has priority over the increment and
//                leaves the other half untouched. Wrapping from all-ones
//                emits a single-cycle ovf_o pulse.
//  Ports       : clk_i, rst_n_i   - clock, async active-low reset
//                inc_i            - count by one this cycle
//                wr_lo_i/wr_hi_i  - load bits [31:0] / [WIDTH-1:32]
//                wdata_i          - 32-bit load value
//                value_o          - current count
//                ovf_o            - counter wraps at the coming edge
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  input  logic             wr_lo_i,
  input  logic             wr_hi_i,
  input  logic [31:0]      wdata_i,
  output logic [WIDTH-1:0] value_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] w_wr_val;
  logic             w_wr;

  generate
    if (WIDTH > 32) begin : g_hi
      assign w_wr = wr_lo_i | wr_hi_i;
      always_comb begin
        w_wr_val = cnt_q;
        if (wr_lo_i) w_wr_val[31:0]       = wdata_i;
        if (wr_hi_i) w_wr_val[WIDTH-1:32] = wdata_i[WIDTH-33:0];
      end
    end else begin : g_lo_only
      // No high half exists; high-half writes are discarded.
      logic w_unused_hi;
      assign w_unused_hi = wr_hi_i;
      assign w_wr        = wr_lo_i;
      assign w_wr_val    = wdata_i[WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    if (w_wr) begin
      cnt_d = w_wr_val;
    end else if (inc_i) begin
      cnt_d = cnt_q + WIDTH'(1);
      ovf_o = &cnt_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/csr_counters.sv
`default_nettype none
// ============================================================================
//  Module      : csr_counters
//  Description : Machine counter / performance-monitor CSR bank: mcycle,
//                minstret, NUM_HPM mhpmcounters, mcountinhibit, mhpmevent
//                selectors, user read-only shadows and a sticky overflow
//                register with a registered interrupt.
//  Ports       : clk_i, rst_n_i   - clock, async active-low reset
//                csr_addr_i       - CSR address
//                csr_wdata_i      - write operand
//                csr_op_i         - READ / WRITE / SET / CLEAR
//                csr_access_i     - valid CSR instruction this cycle
//                csr_rdata_o      - combinational read data
//                csr_hit_o        - address belongs to this block
//                csr_illegal_o    - write attempted to a read-only shadow
//                instr_retired_i  - one instruction retired
//                event_i          - per-cycle event pulses
//                ovf_irq_o        - any overflow bit set (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_counters
  import csr_counters_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  csr_addr_t             csr_addr_i,
  input  logic [31:0]           csr_wdata_i,
  input  logic [1:0]            csr_op_i,
  input  logic                  csr_access_i,
  output logic [31:0]           csr_rdata_o,
  output logic                  csr_hit_o,
  output logic                  csr_illegal_o,
  input  logic                  instr_retired_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  ovf_irq_o
);

  localparam logic [31:0] IMPL_MASK = impl_mask(NUM_HPM);
  localparam bit          HAS_HI    = (CNT_WIDTH > 32);

  // --------------------------------------------------------------------------
  // Address decode
  // --------------------------------------------------------------------------
  logic [4:0] w_idx;
  logic       w_sel_cnt_lo, w_sel_cnt_hi, w_sel_shd_lo, w_sel_shd_hi;
  logic       w_sel_inh, w_sel_evt, w_sel_ovf, w_shadow;

  always_comb begin
    w_idx        = csr_addr_i[4:0];
    // Index 1 (time) is not part of this block.
    w_sel_cnt_lo = (csr_addr_i[11:5] == CNT_LO_PAGE) && (w_idx != 5'd1);
    w_sel_cnt_hi = (csr_addr_i[11:5] == CNT_HI_PAGE) && (w_idx != 5'd1);
    w_sel_shd_lo = (csr_addr_i[11:5] == SHD_LO_PAGE) && (w_idx != 5'd1);
    w_sel_shd_hi = (csr_addr_i[11:5] == SHD_HI_PAGE) && (w_idx != 5'd1);
    w_sel_inh    = (csr_addr_i == CSR_MCOUNTINHIBIT);
    w_sel_evt    = (csr_addr_i[11:5] == EVT_PAGE) && (w_idx >= 5'(HPM_BASE_IDX));
    w_sel_ovf    = (csr_addr_i == CSR_MCOUNTEROVF);
    w_shadow     = w_sel_shd_lo | w_sel_shd_hi;
  end

  // --------------------------------------------------------------------------
  // State and per-counter views (all indexed 0..31; absent entries read 0)
  // --------------------------------------------------------------------------
  logic [31:0] inhibit_q, inhibit_d;
  logic [31:0] ovf_q, ovf_d;
  logic        irq_q, irq_d;
  logic [63:0] w_cnt_ext [32];
  logic [31:0] w_evt_ext [32];
  logic [31:0] w_ovf_pulse;

  // --------------------------------------------------------------------------
  // Read mux and effective write data
  // --------------------------------------------------------------------------
  logic [31:0] w_rdata;
  logic [31:0] w_wdata_eff;
  logic        w_wr_en;
  logic        w_cnt_lo_wr, w_cnt_hi_wr, w_evt_wr, w_inh_wr, w_ovf_wr;

  always_comb begin
    w_rdata = '0;
    if (w_sel_cnt_lo || w_sel_shd_lo)      w_rdata = w_cnt_ext[w_idx][31:0];
    else if (w_sel_cnt_hi || w_sel_shd_hi) w_rdata = w_cnt_ext[w_idx][63:32];
    else if (w_sel_inh)                    w_rdata = inhibit_q;
    else if (w_sel_evt)                    w_rdata = w_evt_ext[w_idx];
    else if (w_sel_ovf)                    w_rdata = ovf_q;
  end

  always_comb begin
    case (csr_op_i)
      CSR_WRITE: w_wdata_eff = csr_wdata_i;
      CSR_SET:   w_wdata_eff = csr_wdata_i | w_rdata;
      CSR_CLEAR: w_wdata_eff = ~csr_wdata_i & w_rdata;
      default:   w_wdata_eff = w_rdata;
    endcase
  end

  // Shadows are read-only: a write there raises illegal and changes nothing.
  assign w_wr_en     = csr_access_i && (csr_op_i != CSR_READ) && !w_shadow;
  assign w_cnt_lo_wr = w_wr_en && w_sel_cnt_lo;
  assign w_cnt_hi_wr = w_wr_en && w_sel_cnt_hi && HAS_HI;
  assign w_evt_wr    = w_wr_en && w_sel_evt;
  assign w_inh_wr    = w_wr_en && w_sel_inh;
  assign w_ovf_wr    = w_wr_en && w_sel_ovf;

  assign csr_rdata_o   = w_rdata;
  assign csr_hit_o     = w_sel_cnt_lo | w_sel_cnt_hi | w_shadow |
                         w_sel_inh | w_sel_evt | w_sel_ovf;
  assign csr_illegal_o = csr_access_i && w_shadow && (csr_op_i != CSR_READ);

  // --------------------------------------------------------------------------
  // Counters and event selectors
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < 32; i++) begin : g_cnt
      if (i == 0 || i == 2 || (i >= HPM_BASE_IDX && i < HPM_BASE_IDX + NUM_HPM))
      begin : g_impl
        logic                 w_inc;
        logic                 w_wr_lo, w_wr_hi, w_ovf;
        logic [CNT_WIDTH-1:0] w_val;

        if (i >= HPM_BASE_IDX) begin : g_hpm
          logic [NUM_EVENTS-1:0] evt_q, evt_d;

          always_comb begin
            evt_d = evt_q;
            if (w_evt_wr && (w_idx == 5'(i))) evt_d = w_wdata_eff[NUM_EVENTS-1:0];
          end

          always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) evt_q <= '0;
            else          evt_q <= evt_d;
          end

          assign w_evt_ext[i] = 32'(evt_q);
          assign w_inc        = (|(event_i & evt_q)) & ~inhibit_q[i];
        end else if (i == 0) begin : g_cycle
          assign w_evt_ext[i] = '0;
          assign w_inc        = ~inhibit_q[0];
        end else begin : g_instret
          assign w_evt_ext[i] = '0;
          assign w_inc        = instr_retired_i & ~inhibit_q[2];
        end

        assign w_wr_lo = w_cnt_lo_wr && (w_idx == 5'(i));
        assign w_wr_hi = w_cnt_hi_wr && (w_idx == 5'(i));

        csr_counter #(
          .WIDTH (CNT_WIDTH)
        ) u_counter (
          .clk_i   (clk_i),
          .rst_n_i (rst_n_i),
          .inc_i   (w_inc),
          .wr_lo_i (w_wr_lo),
          .wr_hi_i (w_wr_hi),
          .wdata_i (w_wdata_eff),
          .value_o (w_val),
          .ovf_o   (w_ovf)
        );

        assign w_cnt_ext[i]   = 64'(w_val);
        assign w_ovf_pulse[i] = w_ovf;
      end else begin : g_none
        assign w_cnt_ext[i]   = '0;
        assign w_evt_ext[i]   = '0;
        assign w_ovf_pulse[i] = 1'b0;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // mcountinhibit, mcounterovf, interrupt
  // --------------------------------------------------------------------------
  always_comb begin
    inhibit_d = inhibit_q;
    if (w_inh_wr) inhibit_d = w_wdata_eff & IMPL_MASK;

    ovf_d = ovf_q;
    if (w_ovf_wr) ovf_d = w_wdata_eff & IMPL_MASK;
    // A wrap in the same cycle as a software clear keeps the bit set.
    ovf_d = ovf_d | w_ovf_pulse;

    irq_d = |ovf_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inhibit_q <= '0;
      ovf_q     <= '0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      ovf_q     <= ovf_d;
      irq_q     <= irq_d;
    end
  end

  assign ovf_irq_o = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_counters.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_counters
//  Description : Directed self-checking bench for csr_counters. A default
//                64-bit instance and a 40-bit instance share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_counters;
  import csr_counters_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [1:0]  csr_op;
  logic        csr_access;
  logic        instr_retired;
  logic [7:0]  event_in;

  logic [31:0] rd64, rd40;
  logic        hit64, hit40, ill64, ill40, irq64, irq40;

  int n_checks = 0;
  int n_fail   = 0;
  int unsigned edges;
  int unsigned exp_cyc;

  always #5 clk = ~clk;

  csr_counters dut (
    .clk_i (clk), .rst_n_i (rst_n),
    .csr_addr_i (csr_addr), .csr_wdata_i (csr_wdata), .csr_op_i (csr_op),
    .csr_access_i (csr_access), .csr_rdata_o (rd64), .csr_hit_o (hit64),
    .csr_illegal_o (ill64), .instr_retired_i (instr_retired),
    .event_i (event_in), .ovf_irq_o (irq64)
  );

  csr_counters #(.NUM_HPM(4), .CNT_WIDTH(40), .NUM_EVENTS(8)) dut40 (
    .clk_i (clk), .rst_n_i (rst_n),
    .csr_addr_i (csr_addr), .csr_wdata_i (csr_wdata), .csr_op_i (csr_op),
    .csr_access_i (csr_access), .csr_rdata_o (rd40), .csr_hit_o (hit40),
    .csr_illegal_o (ill40), .instr_retired_i (instr_retired),
    .event_i (event_in), .ovf_irq_o (irq40)
  );

  // Clock edges seen since reset release: equals mcycle while never inhibited.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One CSR instruction; any write lands on the edge this task waits for.
  task automatic csr_xfer(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd);
    csr_addr   = a;
    csr_op     = op;
    csr_wdata  = wd;
    csr_access = 1'b1;
    @(posedge clk);
    #1;
    csr_access = 1'b0;
    csr_op     = CSR_READ;
  endtask

  task automatic peek(input logic [11:0] a);
    csr_addr = a;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; csr_addr = '0; csr_wdata = '0; csr_op = CSR_READ;
    csr_access = 1'b0; instr_retired = 1'b0; event_in = '0;

    // Reset state
    repeat (2) @(negedge clk);
    peek(CSR_MCYCLE);
    check("rst_mcycle", rd64, 32'h0);
    check("rst_irq", {31'h0, irq64}, 32'h0);
    check("rst_illegal", {31'h0, ill64}, 32'h0);
    peek(CSR_MCOUNTEROVF);
    check("rst_ovf", rd64, 32'h0);

    // Free-running mcycle
    @(negedge clk);
    rst_n = 1'b1;
    csr_addr = CSR_MCYCLE;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("mcycle_10", rd64, 32'd10);

    // minstret: idle, pre-increment read, three retirements
    peek(CSR_MINSTRET);
    check("minstret_idle", rd64, 32'h0);
    @(posedge clk); #1;
    instr_retired = 1'b1;
    @(negedge clk);
    check("minstret_pre", rd64, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    instr_retired = 1'b0;
    check("minstret_3", rd64, 32'd3);
    peek(CSR_INSTRET);
    check("instret_shadow", rd64, 32'd3);

    // Inhibit freezes mcycle (the write edge itself still counts)
    csr_xfer(CSR_MCOUNTINHIBIT, CSR_WRITE, 32'h1);
    exp_cyc = edges;
    csr_addr = CSR_MCYCLE;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mcycle_inhibited", rd64, exp_cyc);
    csr_xfer(CSR_MCOUNTINHIBIT, CSR_WRITE, 32'h0);

    // Low-to-high carry
    csr_xfer(CSR_MCYCLEH, CSR_WRITE, 32'h0);
    csr_xfer(CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFF);
    peek(CSR_MCYCLE);
    check("carry_pre_lo", rd64, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    peek(CSR_MCYCLE);
    check("carry_lo", rd64, 32'h0);
    peek(CSR_MCYCLEH);
    check("carry_hi", rd64, 32'h1);
    check("carry_hi_w40", rd40, 32'h1);

    // Full wrap, sticky overflow, delayed interrupt
    csr_xfer(CSR_MCYCLEH, CSR_WRITE, 32'hFFFF_FFFF);
    peek(CSR_MCYCLEH);
    check("mcycleh_allones", rd64, 32'hFFFF_FFFF);
    check("mcycleh_w40", rd40, 32'h0000_00FF);
    csr_xfer(CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    peek(CSR_MCYCLE);
    check("wrap_lo", rd64, 32'h0);
    check("wrap_lo_w40", rd40, 32'h0);
    peek(CSR_MCYCLEH);
    check("wrap_hi", rd64, 32'h0);
    peek(CSR_MCOUNTEROVF);
    check("wrap_ovf", rd64, 32'h1);
    check("wrap_ovf_w40", rd40, 32'h1);
    check("irq_not_yet", {31'h0, irq64}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("irq_set", {31'h0, irq64}, 32'h1);
    check("irq_set_w40", {31'h0, irq40}, 32'h1);

    // Software clear, then clear colliding with a wrap
    csr_xfer(CSR_MCOUNTEROVF, CSR_CLEAR, 32'h1);
    peek(CSR_MCOUNTEROVF);
    check("ovf_cleared", rd64, 32'h0);
    @(posedge clk); #1;
    check("irq_cleared", {31'h0, irq64}, 32'h0);
    csr_xfer(CSR_MCYCLEH, CSR_WRITE, 32'hFFFF_FFFF);
    csr_xfer(CSR_MCYCLE, CSR_WRITE, 32'hFFFF_FFFF);
    csr_xfer(CSR_MCOUNTEROVF, CSR_CLEAR, 32'h1);
    peek(CSR_MCOUNTEROVF);
    check("ovf_clr_collide", rd64, 32'h1);
    check("ovf_clr_collide_w40", rd40, 32'h1);
    peek(CSR_MCYCLE);
    check("collide_wrap_lo", rd64, 32'h0);

    // HPM counter 3 with an event selector
    csr_xfer(CSR_MHPMEVENT3, CSR_WRITE, 32'h4);
    peek(CSR_MHPMEVENT3);
    check("mhpmevent3", rd64, 32'h4);
    event_in = 8'h04;
    repeat (5) @(posedge clk);
    #1;
    event_in = 8'h02;
    repeat (3) @(posedge clk);
    #1;
    event_in = 8'h00;
    peek(CSR_MHPMCOUNTER3);
    check("hpm3_count", rd64, 32'd5);
    peek(CSR_HPMCOUNTER3);
    check("hpm3_shadow", rd64, 32'd5);
    event_in = 8'h04;
    csr_xfer(CSR_MHPMCOUNTER3, CSR_WRITE, 32'h100);
    event_in = 8'h00;
    peek(CSR_MHPMCOUNTER3);
    check("hpm3_write_wins", rd64, 32'h100);
    csr_xfer(CSR_MHPMEVENT3 + 12'd1, CSR_WRITE, 32'hFFFF_FFFF);
    peek(CSR_MHPMEVENT3 + 12'd1);
    check("mhpmevent4_width", rd64, 32'h0000_00FF);

    // Illegal shadow write
    csr_xfer(CSR_MCOUNTINHIBIT, CSR_WRITE, 32'h1);
    csr_xfer(CSR_MCYCLEH, CSR_WRITE, 32'h0);
    csr_xfer(CSR_MCYCLE, CSR_WRITE, 32'h1234);
    csr_addr = CSR_CYCLE; csr_op = CSR_WRITE; csr_wdata = 32'h0; csr_access = 1'b1;
    #1;
    check("illegal_write", {31'h0, ill64}, 32'h1);
    check("shadow_hit", {31'h0, hit64}, 32'h1);
    @(posedge clk); #1;
    csr_op = CSR_READ;
    #1;
    check("illegal_read", {31'h0, ill64}, 32'h0);
    check("shadow_read", rd64, 32'h1234);
    csr_access = 1'b0;
    peek(CSR_MCYCLE);
    check("mcycle_after_illegal", rd64, 32'h1234);

    // Unimplemented HPM index and unrelated address
    peek(12'hB07);
    check("unimpl_hit", {31'h0, hit64}, 32'h1);
    check("unimpl_read", rd64, 32'h0);
    csr_xfer(12'hB07, CSR_WRITE, 32'h55);
    peek(12'hB07);
    check("unimpl_write", rd64, 32'h0);
    peek(12'h300);
    check("miss_hit", {31'h0, hit64}, 32'h0);

    // mcountinhibit masking and SET/CLEAR
    csr_xfer(CSR_MCOUNTINHIBIT, CSR_WRITE, 32'hFFFF_FFFF);
    peek(CSR_MCOUNTINHIBIT);
    check("inhibit_mask", rd64, 32'h0000_007D);
    csr_xfer(CSR_MCOUNTINHIBIT, CSR_CLEAR, 32'h0000_007C);
    peek(CSR_MCOUNTINHIBIT);
    check("inhibit_clear", rd64, 32'h1);
    csr_xfer(CSR_MCOUNTINHIBIT, CSR_SET, 32'h4);
    peek(CSR_MCOUNTINHIBIT);
    check("inhibit_set", rd64, 32'h5);

    // Asynchronous reset mid-count, then resume
    @(posedge clk); #2;
    rst_n = 1'b0;
    peek(CSR_MCYCLE);
    check("async_rst_mcycle", rd64, 32'h0);
    check("async_rst_irq", {31'h0, irq64}, 32'h0);
    peek(CSR_MCOUNTINHIBIT);
    check("async_rst_inhibit", rd64, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    csr_addr = CSR_MCYCLE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("resume_mcycle", rd64, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
